qmult_seq: RTL



---
 rtl/qfix_pkg.sv | 24 ++
 rtl/qmult_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/qfix_pkg.sv
// ---------------------------------------------------------------------------
// qfix_pkg -- shared definitions for the sign-magnitude Q-format datapath
// (qmult_seq, qadd).
//   QFIX_Q / QFIX_N : default fractional bits / total word width
//   QFIX_MAG_W      : magnitude width (N-1)
//   QFIX_PROD_W     : full magnitude product width (2N-2)
//   QFIX_CNT_W      : shift-add step counter width, clog2(N-1)
//   qfix_state_e    : multiplier FSM encoding (IDLE=0, CALC=1, DONE=2)
// ---------------------------------------------------------------------------
package qfix_pkg;

  localparam int QFIX_Q      = 15;
  localparam int QFIX_N      = 32;
  localparam int QFIX_MAG_W  = QFIX_N - 1;
  localparam int QFIX_PROD_W = 2 * QFIX_N - 2;
  localparam int QFIX_CNT_W  = $clog2(QFIX_N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } qfix_state_e;

endpackage

// File: rtl/qmult_seq.sv
// ---------------------------------------------------------------------------
// qmult_seq -- multi-cycle sign-magnitude fixed-point multiplier.
// One shift-add step per clock; N-1 steps per product, no early-out.
//
// Ports:
//   clk        : clock, all state changes on rising edge
//   rst        : synchronous active-high reset, aborts any operation
//   in_valid   : a/b valid
//   in_ready   : block idle and able to accept operands
//   a, b       : multiplicand / multiplier, sign-magnitude Q format
//   out_valid  : c/ovf valid, held until out_ready
//   out_ready  : consumer accepts the result
//   c          : product, sign-magnitude Q format (truncated toward zero)
//   ovf        : product magnitude exceeds N-1 bits
//
// Build option: define QMULT_SAT_EN to saturate the magnitude of c to
// all-ones when ovf is set. ovf itself is identical in both builds.
// ---------------------------------------------------------------------------
module qmult_seq
  import qfix_pkg::*;
#(
  parameter int Q = QFIX_Q,
  parameter int N = QFIX_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  localparam int MAG_W  = N - 1;
  localparam int PROD_W = 2 * N - 2;
  localparam int CNT_W  = $clog2(N - 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 2);

  qfix_state_e        r_state;
  logic               r_sign;
  logic [MAG_W-1:0]   r_mcand;
  logic [MAG_W-1:0]   r_mplier;
  logic [PROD_W-1:0]  r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [N-1:0]       r_c;
  logic               r_ovf;
  logic               r_out_valid;
  logic               r_in_ready;

  logic [PROD_W-1:0]  w_addend;
  logic [PROD_W-1:0]  w_acc_next;
  logic               w_ovf_next;
  logic [MAG_W-1:0]   w_mag;
  logic [N-1:0]       w_c_next;

  // Accumulator value after the current step; on the last step this is the
  // final product, so the result can be registered on that same edge.
  always_comb begin
    w_addend = '0;
    if (r_mplier[r_cnt])
      w_addend = {{(PROD_W - MAG_W){1'b0}}, r_mcand} << r_cnt;
    w_acc_next = r_acc + w_addend;
    w_ovf_next = |w_acc_next[PROD_W-1:Q+N-1];
`ifdef QMULT_SAT_EN
    w_mag = w_ovf_next ? {MAG_W{1'b1}} : w_acc_next[Q+N-2:Q];
`else
    w_mag = w_acc_next[Q+N-2:Q];
`endif
    // A zero magnitude always carries a positive sign (no negative zero).
    w_c_next = {r_sign & (|w_mag), w_mag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_c         <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sign     <= a[N-1] ^ b[N-1];
            r_mcand    <= a[N-2:0];
            r_mplier   <= b[N-2:0];
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_c         <= w_c_next;
            r_ovf       <= w_ovf_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign c         = r_c;
  assign ovf       = r_ovf;

endmodule
